axi_rd_arbiter: RTL and testbench

- Shares the single AXI read-address (AR) and read-data (R) channel pair between the instruction-fetch requester and the data-load requester.
- Arbitrates AR issue, with data-load priority and a read-after-write hazard stall.
- Tracks outstanding reads per ID and routes R beats back by rid, with a registered data_ok and rdata.
- Sits between the core's SRAM-style request ports and the AXI bridge's read channels; the write side stays separate and supplies only hazard information.

---
 rtl/axi_rd_arbiter_if.sv | 59 +++++
 rtl/axi_rd_arbiter.sv | 169 ++++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_rd_arbiter_if.sv
// ---------------------------------------------------------------------------
// axi_rd_arbiter_if
//   Bundles every signal of the read arbiter except clock and reset: the two
//   SRAM-style core request ports (inst_*, data_*), the write-side hazard
//   inputs (wr_pending, wr_addr) and the shared AXI AR/R channel pair.
//
//   modport slave  : the arbiter's view (core requests in, AXI AR out, R in).
//   modport master : the surrounding system's view (core + AXI bridge).
// ---------------------------------------------------------------------------
interface axi_rd_arbiter_if;
  // instruction-fetch port
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [1:0]  inst_size;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  // data-load port
  logic        data_req;
  logic [31:0] data_addr;
  logic [1:0]  data_size;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  // write-side hazard info
  logic        wr_pending;
  logic [31:0] wr_addr;
  // AXI read address channel
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic        arvalid;
  logic        arready;
  // AXI read data channel
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rready;

  modport slave (
    input  inst_req, inst_addr, inst_size,
    input  data_req, data_addr, data_size,
    input  wr_pending, wr_addr,
    input  arready, rid, rdata, rvalid,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output arid, araddr, arsize, arvalid, rready
  );

  modport master (
    output inst_req, inst_addr, inst_size,
    output data_req, data_addr, data_size,
    output wr_pending, wr_addr,
    output arready, rid, rdata, rvalid,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  arid, araddr, arsize, arvalid, rready
  );
endinterface

// File: rtl/axi_rd_arbiter.sv
// ---------------------------------------------------------------------------
// axi_rd_arbiter
//   Shares one AXI AR/R channel pair between the instruction-fetch and the
//   data-load requesters.
//   - AR issue: two-state FSM (IDLE grants, ISSUE holds arvalid until
//     arready). Data has fixed priority; a data load whose word address
//     matches a pending write is held back without blocking fetch.
//   - Each ID keeps an outstanding-read counter capped at MAX_OUTST.
//   - R beats are routed by rid[0] into per-ID registered rdata/data_ok.
//     Beats for an ID with nothing outstanding are dropped.
//
// Ports
//   aclk   : clock
//   reset  : synchronous, active-high reset
//   bus    : axi_rd_arbiter_if.slave (core ports, hazard info, AXI AR/R)
//
// Parameters
//   MAX_OUTST : max outstanding reads per ID
//   CNT_W     : counter width, 2**CNT_W must exceed MAX_OUTST
// ---------------------------------------------------------------------------

// Per-ID lane: outstanding counter plus registered response.
//   ar_hs     : AR handshake for this ID
//   r_beat    : R handshake whose rid[0] selects this ID
//   r_data    : R data bus
//   can_issue : counter below MAX_OUTST
//   data_ok   : one-cycle pulse the cycle after an accepted beat
//   rdata_q   : last accepted beat for this ID
module axi_rd_arbiter_lane #(
  parameter int MAX_OUTST = 4,
  parameter int CNT_W     = 3
) (
  input  logic        aclk,
  input  logic        reset,
  input  logic        ar_hs,
  input  logic        r_beat,
  input  logic [31:0] r_data,
  output logic        can_issue,
  output logic        data_ok,
  output logic [31:0] rdata_q
);
  logic [CNT_W-1:0] cnt;
  logic             accept;

  // A beat with nothing outstanding is unexpected: no pulse, no decrement.
  assign accept    = r_beat & (cnt != '0);
  assign can_issue = (cnt < CNT_W'(MAX_OUTST));

  always_ff @(posedge aclk) begin
    if (reset) begin
      cnt     <= '0;
      data_ok <= 1'b0;
      rdata_q <= '0;
    end else begin
      data_ok <= accept;
      if (accept) rdata_q <= r_data;
      // Issue and retire in the same cycle cancel out.
      case ({ar_hs, accept})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

module axi_rd_arbiter #(
  parameter int MAX_OUTST = 4,
  parameter int CNT_W     = 3
) (
  input logic              aclk,
  input logic              reset,
  axi_rd_arbiter_if.slave  bus
);
  localparam int NUM_IDS = 2;   // lane 0 = inst, lane 1 = data (== arid[0])

  typedef enum logic {IDLE, ISSUE} state_t;

  typedef struct packed {
    logic        id;
    logic [31:0] addr;
    logic [1:0]  size;
  } ar_req_t;

  state_t  state, state_nxt;
  ar_req_t ar_q, ar_nxt;

  logic hazard, data_elig, inst_elig, ar_hs, r_fire;
  logic [NUM_IDS-1:0]        can_issue, lane_ar_hs, lane_r_beat, lane_data_ok;
  logic [NUM_IDS-1:0][31:0]  lane_rdata;
  logic [4:0]                unused_bits;

  // Only rid[0] selects the lane; write hazard compares word addresses.
  assign unused_bits = {bus.rid[3:1], bus.wr_addr[1:0]};

  // Hazard only matters at grant time; once latched the read is committed.
  assign hazard    = bus.wr_pending & (bus.wr_addr[31:2] == bus.data_addr[31:2]);
  assign data_elig = bus.data_req & ~hazard & can_issue[1];
  assign inst_elig = bus.inst_req & can_issue[0];

  always_comb begin
    state_nxt = state;
    ar_nxt    = ar_q;
    case (state)
      IDLE: begin
        if (data_elig) begin
          ar_nxt    = '{id: 1'b1, addr: bus.data_addr, size: bus.data_size};
          state_nxt = ISSUE;
        end else if (inst_elig) begin
          ar_nxt    = '{id: 1'b0, addr: bus.inst_addr, size: bus.inst_size};
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.arready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      state <= IDLE;
      ar_q  <= '0;
    end else begin
      state <= state_nxt;
      ar_q  <= ar_nxt;
    end
  end

  // AR channel: fields come straight from the latched request, so they are
  // stable for the whole time arvalid is high.
  assign bus.arvalid = (state == ISSUE);
  assign bus.arid    = {3'b000, ar_q.id};
  assign bus.araddr  = ar_q.addr;
  assign bus.arsize  = {1'b0, ar_q.size};
  assign ar_hs       = bus.arvalid & bus.arready;

  assign bus.inst_addr_ok = ar_hs & ~ar_q.id;
  assign bus.data_addr_ok = ar_hs &  ar_q.id;

  // Responses are always sunk; no backpressure toward the slave.
  assign bus.rready = ~reset;
  assign r_fire     = bus.rvalid & bus.rready;

  for (genvar i = 0; i < NUM_IDS; i++) begin : g_lane
    assign lane_ar_hs[i]  = ar_hs  & (ar_q.id    == 1'(i));
    assign lane_r_beat[i] = r_fire & (bus.rid[0] == 1'(i));

    axi_rd_arbiter_lane #(
      .MAX_OUTST (MAX_OUTST),
      .CNT_W     (CNT_W)
    ) u_lane (
      .aclk      (aclk),
      .reset     (reset),
      .ar_hs     (lane_ar_hs[i]),
      .r_beat    (lane_r_beat[i]),
      .r_data    (bus.rdata),
      .can_issue (can_issue[i]),
      .data_ok   (lane_data_ok[i]),
      .rdata_q   (lane_rdata[i])
    );
  end

  assign bus.inst_data_ok = lane_data_ok[0];
  assign bus.inst_rdata   = lane_rdata[0];
  assign bus.data_data_ok = lane_data_ok[1];
  assign bus.data_rdata   = lane_rdata[1];
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter. Expected AR beats and R data are queued
// when stimulus is driven and compared when the DUT presents them.
module tb_axi_rd_arbiter;
  logic aclk = 1'b0;
  logic reset;
  always #5 aclk = ~aclk;

  axi_rd_arbiter_if bus();

  axi_rd_arbiter #(.MAX_OUTST(4), .CNT_W(3)) dut (
    .aclk  (aclk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [38:0] arq[$];        // {arid, araddr, arsize}
  logic [31:0] iq[$], dq[$];  // expected inst / data read data
  int  mcnt[2];               // model outstanding count per ID
  bit  drop_inst, drop_data;
  int  inst_ok_n, data_ok_n, inst_ok_cyc, data_ok_cyc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs at the falling edge: everything seen here is what the next rising
  // edge will act on.
  task automatic monitor();
    logic [38:0] e;
    logic [31:0] d;
    int          r;
    cyc++;
    drop_inst = 1'b0;
    drop_data = 1'b0;
    chk("rready", bus.rready, !reset);
    if (reset) begin
      arq.delete(); iq.delete(); dq.delete();
      mcnt[0] = 0; mcnt[1] = 0;
      return;
    end
    chk("data_ok_both", bus.inst_data_ok & bus.data_data_ok, 0);
    if (iq.size() == 0) chk("inst_data_ok_unexp", bus.inst_data_ok, 0);
    else if (bus.inst_data_ok) begin
      d = iq.pop_front();
      chk("inst_rdata", bus.inst_rdata, d);
    end
    if (dq.size() == 0) chk("data_data_ok_unexp", bus.data_data_ok, 0);
    else if (bus.data_data_ok) begin
      d = dq.pop_front();
      chk("data_rdata", bus.data_rdata, d);
    end
    // R beat judged against the count before this cycle's AR
    if (bus.rvalid && bus.rready) begin
      r = int'(bus.rid[0]);
      if (mcnt[r] > 0) begin
        if (r == 1) dq.push_back(bus.rdata); else iq.push_back(bus.rdata);
        mcnt[r]--;
      end
    end
    if (bus.arvalid && bus.arready) begin
      if (arq.size() == 0) chk("ar_unexp", bus.arvalid, 0);
      else begin
        e = arq.pop_front();
        chk("ar_fields", {bus.arid, bus.araddr, bus.arsize}, e);
        chk("addr_ok", {bus.inst_addr_ok, bus.data_addr_ok}, e[35] ? 2'b01 : 2'b10);
        if (e[35]) begin
          mcnt[1]++; drop_data = 1'b1; data_ok_n++; data_ok_cyc = cyc;
        end else begin
          mcnt[0]++; drop_inst = 1'b1; inst_ok_n++; inst_ok_cyc = cyc;
        end
      end
    end else begin
      chk("addr_ok_idle", {bus.inst_addr_ok, bus.data_addr_ok}, 2'b00);
    end
  endtask

  task automatic step();
    @(negedge aclk);
    monitor();
    @(posedge aclk);
    #1;
    if (drop_inst) bus.inst_req = 1'b0;
    if (drop_data) bus.data_req = 1'b0;
  endtask

  task automatic issue_inst(input logic [31:0] a, input logic [1:0] s);
    arq.push_back({4'h0, a, 1'b0, s});
    bus.inst_addr = a; bus.inst_size = s; bus.inst_req = 1'b1;
  endtask

  task automatic issue_data(input logic [31:0] a, input logic [1:0] s);
    arq.push_back({4'h1, a, 1'b0, s});
    bus.data_addr = a; bus.data_size = s; bus.data_req = 1'b1;
  endtask

  task automatic r_beat(input logic [3:0] id, input logic [31:0] d);
    bus.rvalid = 1'b1; bus.rid = id; bus.rdata = d;
    step();
    bus.rvalid = 1'b0;
  endtask

  task automatic wait_done(input bit wi, input bit wd, input int max);
    int n = 0;
    while (((wi && bus.inst_req) || (wd && bus.data_req)) && n < max) begin
      step();
      n++;
    end
    chk("wait_timeout", {wi & bus.inst_req, wd & bus.data_req}, 2'b00);
  endtask

  initial begin
    reset = 1'b1;
    bus.inst_req = 0; bus.inst_addr = 0; bus.inst_size = 0;
    bus.data_req = 0; bus.data_addr = 0; bus.data_size = 0;
    bus.wr_pending = 0; bus.wr_addr = 0;
    bus.arready = 1; bus.rid = 0; bus.rdata = 0; bus.rvalid = 0;
    repeat (2) step();
    reset = 1'b0;

    // reset state
    chk("rst_arvalid", bus.arvalid, 0);
    chk("rst_arid", bus.arid, 0);
    chk("rst_araddr", bus.araddr, 0);
    chk("rst_arsize", bus.arsize, 0);
    chk("rst_data_ok", {bus.inst_data_ok, bus.data_data_ok}, 2'b00);
    chk("rst_inst_rdata", bus.inst_rdata, 0);
    chk("rst_data_rdata", bus.data_rdata, 0);

    // 1: single data load
    issue_data(32'h1C00_0100, 2'd2);
    step();
    chk("t1_arvalid", bus.arvalid, 1);
    chk("t1_araddr", bus.araddr, 32'h1C00_0100);
    wait_done(0, 1, 10);
    r_beat(4'h1, 32'hDEAD_BEEF);
    chk("t1_data_ok", bus.data_data_ok, 1);
    chk("t1_data_rdata", bus.data_rdata, 32'hDEAD_BEEF);
    step();

    // 2: simultaneous requests, data first, inst two cycles later
    inst_ok_n = 0; data_ok_n = 0;
    issue_data(32'h1C00_0200, 2'd2);
    issue_inst(32'hBFC0_0000, 2'd2);
    wait_done(1, 1, 20);
    chk("t2_data_once", data_ok_n, 1);
    chk("t2_inst_once", inst_ok_n, 1);
    chk("t2_gap", inst_ok_cyc - data_ok_cyc, 2);
    r_beat(4'h1, 32'hA5A5_0001);
    r_beat(4'h0, 32'h5A5A_0002);
    step();

    // 3: RAW hazard stalls data but not inst
    bus.wr_pending = 1'b1; bus.wr_addr = 32'h0000_0100;
    issue_inst(32'h0000_0200, 2'd1);
    issue_data(32'h0000_0102, 2'd0);
    wait_done(1, 0, 10);
    repeat (3) begin
      step();
      chk("t3_stall_arvalid", bus.arvalid, 0);
    end
    chk("t3_data_pending", bus.data_req, 1);
    bus.wr_pending = 1'b0;
    wait_done(0, 1, 10);
    r_beat(4'h0, 32'h0000_C0DE);
    r_beat(4'h1, 32'h0000_F00D);
    // pending write to a different word does not stall
    bus.wr_pending = 1'b1; bus.wr_addr = 32'h0000_0104;
    issue_data(32'h0000_0102, 2'd2);
    wait_done(0, 1, 10);
    bus.wr_pending = 1'b0;
    r_beat(4'h1, 32'h0000_BEEF);
    step();

    // 4: inst counter full at 4
    for (int k = 0; k < 4; k++) begin
      issue_inst(32'h0000_1000 + 32'(k * 4), 2'd2);
      wait_done(1, 0, 10);
    end
    issue_inst(32'h0000_1010, 2'd2);
    repeat (4) begin
      step();
      chk("t4_full_arvalid", bus.arvalid, 0);
    end
    r_beat(4'h0, 32'h4000_0000);
    wait_done(1, 0, 10);
    for (int k = 1; k <= 4; k++) r_beat(4'h0, 32'h4000_0000 + 32'(k));
    step();

    // 5: AR and R for data in the same cycle; spurious R
    issue_data(32'h0000_3000, 2'd2);
    wait_done(0, 1, 10);
    issue_data(32'h0000_3004, 2'd2);
    step();
    bus.rvalid = 1'b1; bus.rid = 4'h3; bus.rdata = 32'h5555_0001;
    step();
    bus.rvalid = 1'b0;
    chk("t5_hs_data_ok", bus.data_data_ok, 1);
    chk("t5_hs_rdata", bus.data_rdata, 32'h5555_0001);
    r_beat(4'h1, 32'h5555_0002);
    chk("t5_last_data_ok", bus.data_data_ok, 1);
    r_beat(4'h1, 32'h5555_0003);
    chk("t5_extra_dropped", bus.data_data_ok, 0);
    chk("t5_rdata_held", bus.data_rdata, 32'h5555_0002);
    r_beat(4'h0, 32'hBAD0_BAD0);
    chk("t5_spurious_inst", bus.inst_data_ok, 0);
    chk("t5_inst_rdata_held", bus.inst_rdata, 32'h4000_0004);
    step();

    // 6: reset during ISSUE
    issue_inst(32'h0000_4000, 2'd2);
    wait_done(1, 0, 10);
    issue_data(32'h0000_5000, 2'd2);
    wait_done(0, 1, 10);
    bus.arready = 1'b0;
    issue_data(32'h0000_6000, 2'd2);
    step();
    step();
    chk("t6_issue_arvalid", bus.arvalid, 1);
    chk("t6_issue_araddr", bus.araddr, 32'h0000_6000);
    reset = 1'b1; bus.data_req = 1'b0;
    step();
    chk("t6_rst_arvalid", bus.arvalid, 0);
    chk("t6_rst_data_ok", {bus.inst_data_ok, bus.data_data_ok}, 2'b00);
    chk("t6_rst_rready", bus.rready, 0);
    reset = 1'b0; bus.arready = 1'b1;
    step();
    chk("t6_arid", bus.arid, 0);
    chk("t6_araddr", bus.araddr, 0);
    r_beat(4'h0, 32'h6666_0000);
    chk("t6_inst_cnt_clear", bus.inst_data_ok, 0);
    r_beat(4'h1, 32'h6666_0001);
    chk("t6_data_cnt_clear", bus.data_data_ok, 0);
    step();

    chk("sb_ar_empty", arq.size(), 0);
    chk("sb_inst_empty", iq.size(), 0);
    chk("sb_data_empty", dq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
